// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, default framing byte and the saturating
// counter helper used by the controller packet receiver.
package ctrl_pkg;

    typedef enum logic [2:0] {WAIT_START, ID, BUTTONS, AXES, CHECK} state_t;

    localparam logic [7:0] START_CHAR_DEF = 8'hFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/ctrl_packet_rx_timeout.sv
// ctrl_packet_rx_timeout: saturating cycle counter with clear and enable; tc is
// high while the count equals LIMIT.
//   clk_in, rst_in : clock, asynchronous active-high reset (loads RST_VAL)
//   clr            : synchronous clear to zero (wins over en)
//   en             : count one per cycle, holding at LIMIT
//   tc             : terminal count (count == LIMIT)
module ctrl_packet_rx_timeout #(
    parameter int LIMIT   = 1023,
    parameter int RST_VAL = 0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign tc = cnt == W'(LIMIT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt <= W'(RST_VAL);
        else if (clr) cnt <= '0;
        else if (en && !tc) cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/ctrl_packet_rx.sv
// ctrl_packet_rx: framed multi-controller packet decoder with XOR checksum,
// inter-byte timeout and atomic per-controller commit.
// Optional stale flags are built when CTRL_PACKET_RX_STALE_EN is defined.
//   clk_in, rst_in      : clock, asynchronous active-high reset
//   byte_in             : received byte from spi_con
//   byte_valid_in       : one-cycle strobe qualifying byte_in
//   buttons_out         : controller c at [c*NUM_BUTTONS +: NUM_BUTTONS]
//   axes_out            : axis a of controller c at [(c*NUM_AXES+a)*8 +: 8]
//   update_out          : one-cycle commit pulse per controller
//   pkt_ok_count        : committed packets, saturating
//   pkt_err_count       : checksum, ID and timeout errors, saturating
//   stale_out           : controller not refreshed for STALE_CYCLES cycles
module ctrl_packet_rx
    import ctrl_pkg::*;
#(
    parameter int         NUM_CTRL       = 2,
    parameter int         NUM_BUTTONS    = 8,
    parameter int         NUM_AXES       = 2,
    parameter logic [7:0] START_CHAR     = START_CHAR_DEF,
    parameter int         TIMEOUT_CYCLES = 1024
`ifdef CTRL_PACKET_RX_STALE_EN
    ,
    parameter int         STALE_CYCLES   = 2**20
`endif
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [7:0]                     byte_in,
    input  logic                           byte_valid_in,
    output logic [NUM_CTRL*NUM_BUTTONS-1:0] buttons_out,
    output logic [NUM_CTRL*NUM_AXES*8-1:0]  axes_out,
    output logic [NUM_CTRL-1:0]             update_out,
    output logic [15:0]                     pkt_ok_count,
    output logic [15:0]                     pkt_err_count,
    output logic [NUM_CTRL-1:0]             stale_out
);

    localparam int IW = $clog2(NUM_BUTTONS + NUM_AXES + 1);

    state_t                 state, nxt;
    logic [IW-1:0]          idx;
    logic [7:0]             id_r, xor_r;
    logic [NUM_BUTTONS-1:0] tmp_btn;
    logic [NUM_AXES*8-1:0]  tmp_axes;
    logic                   idle_tc, timeout, chk_ok, chk_err;

    // The limit cycle only times out if no byte arrives in it.
    assign timeout = state != WAIT_START && !byte_valid_in && idle_tc;
    assign chk_ok  = state == CHECK && byte_valid_in && byte_in == xor_r && id_r < 8'(NUM_CTRL);
    assign chk_err = (state == CHECK && byte_valid_in && !chk_ok) || timeout;

    // tc marks the TIMEOUT_CYCLES-th idle cycle since the last byte.
    ctrl_packet_rx_timeout #(.LIMIT(TIMEOUT_CYCLES - 1)) u_idle (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (state == WAIT_START || byte_valid_in),
        .en     (1'b1),
        .tc     (idle_tc)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= WAIT_START;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            WAIT_START: nxt = (byte_valid_in && byte_in == START_CHAR) ? ID : WAIT_START;
            ID:         nxt = byte_valid_in ? BUTTONS : ID;
            BUTTONS:    nxt = (byte_valid_in && idx == IW'(NUM_BUTTONS - 1)) ? AXES : BUTTONS;
            AXES:       nxt = (byte_valid_in && idx == IW'(NUM_BUTTONS + NUM_AXES - 1)) ? CHECK : AXES;
            CHECK:      nxt = byte_valid_in ? WAIT_START : CHECK;
            default:    nxt = WAIT_START;
        endcase
        if (timeout) nxt = WAIT_START;
    end

    // idx runs across buttons then axes, so axis a sits at idx NUM_BUTTONS+a.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx           <= '0;
            id_r          <= '0;
            xor_r         <= '0;
            tmp_btn       <= '0;
            tmp_axes      <= '0;
            buttons_out   <= '0;
            axes_out      <= '0;
            update_out    <= '0;
            pkt_ok_count  <= '0;
            pkt_err_count <= '0;
        end else begin
            update_out    <= '0;
            pkt_ok_count  <= sat_inc16(pkt_ok_count, chk_ok);
            pkt_err_count <= sat_inc16(pkt_err_count, chk_err);
            if (byte_valid_in && state == ID) begin
                id_r  <= byte_in;
                xor_r <= byte_in;
                idx   <= '0;
            end
            if (byte_valid_in && (state == BUTTONS || state == AXES)) begin
                xor_r <= xor_r ^ byte_in;
                idx   <= idx + IW'(1);
            end
            if (byte_valid_in && state == BUTTONS)
                tmp_btn <= {tmp_btn[NUM_BUTTONS-2:0], byte_in[0]};
            if (byte_valid_in && state == AXES)
                for (int a = 0; a < NUM_AXES; a++)
                    if (idx == IW'(NUM_BUTTONS + a)) tmp_axes[a*8 +: 8] <= byte_in;
            if (chk_ok)
                for (int c = 0; c < NUM_CTRL; c++)
                    if (id_r == 8'(c)) begin
                        buttons_out[c*NUM_BUTTONS +: NUM_BUTTONS] <= tmp_btn;
                        axes_out[c*NUM_AXES*8 +: NUM_AXES*8]      <= tmp_axes;
                        update_out[c]                             <= 1'b1;
                    end
        end
    end

`ifdef CTRL_PACKET_RX_STALE_EN
    // Counters reset to the limit so every controller starts out stale.
    for (genvar c = 0; c < NUM_CTRL; c++) begin : g_stale
        ctrl_packet_rx_timeout #(.LIMIT(STALE_CYCLES), .RST_VAL(STALE_CYCLES)) u_stale (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .clr    (chk_ok && id_r == 8'(c)),
            .en     (1'b1),
            .tc     (stale_out[c])
        );
    end
`else
    assign stale_out = '0;
`endif

endmodule

// File: tb/tb_ctrl_packet_rx.sv
// tb_ctrl_packet_rx: table-driven check of ctrl_packet_rx plus timeout and reset sequences.
module tb_ctrl_packet_rx;

    localparam int TO = 1024;

    logic        clk_in = 1'b0, rst_in = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid_in = 1'b0;
    logic [15:0] buttons_out;
    logic [31:0] axes_out;
    logic [1:0]  update_out, stale_out;
    logic [15:0] pkt_ok_count, pkt_err_count;

    int n_vec = 0, n_err = 0;

    ctrl_packet_rx dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid_in),
        .buttons_out   (buttons_out),
        .axes_out      (axes_out),
        .update_out    (update_out),
        .pkt_ok_count  (pkt_ok_count),
        .pkt_err_count (pkt_err_count),
        .stale_out     (stale_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  btn;
        logic [6:0]  hi;
        logic [15:0] ax;
        logic        flip;
        logic [1:0]  upd;
        logic [15:0] btn_o;
        logic [31:0] ax_o;
        logic [15:0] ok;
        logic [15:0] err;
    } vec_t;

    vec_t v[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid_in = 1'b1;
        @(negedge clk_in);
        byte_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid_in = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    // Button bit i (MSB first) travels as {hi, bit}; checksum covers full bytes.
    task automatic send_pkt(input logic [7:0] id, input logic [7:0] btn, input logic [6:0] hi,
                            input logic [15:0] ax, input logic flip, input int gap);
        logic [7:0] x, b;
        send(8'hFF);
        send(id);
        x = id;
        for (int i = 7; i >= 0; i--) begin
            b = {hi, btn[i]};
            x ^= b;
            send(b);
        end
        x ^= ax[7:0] ^ ax[15:8];
        send(ax[7:0]);
        send(ax[15:8]);
        if (gap > 0) idle(gap);
        send(x ^ {7'b0, flip});
    endtask

    task automatic check_state(input string nm, input logic [1:0] upd, input logic [15:0] b,
                               input logic [31:0] a, input logic [15:0] ok, input logic [15:0] err);
        check({nm, " update"}, 64'(update_out), 64'(upd));
        check({nm, " buttons"}, 64'(buttons_out), 64'(b));
        check({nm, " axes"}, 64'(axes_out), 64'(a));
        check({nm, " ok_count"}, 64'(pkt_ok_count), 64'(ok));
        check({nm, " err_count"}, 64'(pkt_err_count), 64'(err));
        @(negedge clk_in);
        check({nm, " update_clear"}, 64'(update_out), 64'(0));
    endtask

    initial begin
        v[0] = '{8'h01, 8'hAB, 7'h00, 16'h8040, 1'b0, 2'b10, 16'hAB00, 32'h8040_0000, 16'd1, 16'd0};
        v[1] = '{8'h01, 8'hAB, 7'h00, 16'h8040, 1'b1, 2'b00, 16'hAB00, 32'h8040_0000, 16'd1, 16'd1};
        v[2] = '{8'h02, 8'hAB, 7'h00, 16'h8040, 1'b0, 2'b00, 16'hAB00, 32'h8040_0000, 16'd1, 16'd2};
        v[3] = '{8'h00, 8'h5A, 7'h00, 16'h3412, 1'b0, 2'b01, 16'hAB5A, 32'h8040_3412, 16'd2, 16'd2};
        v[4] = '{8'h01, 8'h00, 7'h00, 16'hFFFF, 1'b0, 2'b10, 16'h005A, 32'hFFFF_3412, 16'd3, 16'd2};
        v[5] = '{8'h00, 8'hC3, 7'h55, 16'h0000, 1'b0, 2'b01, 16'h00C3, 32'hFFFF_0000, 16'd4, 16'd2};
        v[6] = '{8'hFF, 8'h11, 7'h00, 16'h2211, 1'b0, 2'b00, 16'h00C3, 32'hFFFF_0000, 16'd4, 16'd3};

        repeat (2) @(negedge clk_in);
        check("reset buttons", 64'(buttons_out), 64'(0));
        check("reset axes", 64'(axes_out), 64'(0));
        check("reset update", 64'(update_out), 64'(0));
        check("reset ok", 64'(pkt_ok_count), 64'(0));
        check("reset err", 64'(pkt_err_count), 64'(0));
`ifdef CTRL_PACKET_RX_STALE_EN
        check("reset stale", 64'(stale_out), 64'(2'b11));
`else
        check("reset stale", 64'(stale_out), 64'(0));
`endif
        rst_in = 1'b0;
        @(negedge clk_in);

        send(8'h00);
        send(8'h12);
        for (int i = 0; i < 7; i++) begin
            send_pkt(v[i].id, v[i].btn, v[i].hi, v[i].ax, v[i].flip, 0);
            check_state($sformatf("vec%0d", i), v[i].upd, v[i].btn_o, v[i].ax_o, v[i].ok, v[i].err);
        end
`ifdef CTRL_PACKET_RX_STALE_EN
        check("stale after commits", 64'(stale_out), 64'(0));
`endif

        send(8'hFF);
        send(8'h00);
        send(8'h01);
        idle(TO - 1);
        check("timeout not yet", 64'(pkt_err_count), 64'(3));
        idle(1);
        check("timeout err", 64'(pkt_err_count), 64'(4));
        send_pkt(8'h01, 8'h0F, 7'h00, 16'h5566, 1'b0, 0);
        check_state("after timeout", 2'b10, 16'h0FC3, 32'h5566_0000, 16'd5, 16'd4);

        send_pkt(8'h00, 8'hF0, 7'h00, 16'h7788, 1'b0, TO - 1);
        check_state("byte at limit", 2'b01, 16'h0FF0, 32'h5566_7788, 16'd6, 16'd4);

        send(8'hFF);
        send(8'h01);
        send(8'h01);
        #2 rst_in = 1'b1;
        #1;
        check("async buttons", 64'(buttons_out), 64'(0));
        check("async axes", 64'(axes_out), 64'(0));
        check("async ok", 64'(pkt_ok_count), 64'(0));
        check("async err", 64'(pkt_err_count), 64'(0));
`ifdef CTRL_PACKET_RX_STALE_EN
        check("async stale", 64'(stale_out), 64'(2'b11));
`endif
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        send_pkt(8'h01, 8'hAB, 7'h00, 16'h8040, 1'b0, 0);
        check_state("after reset", 2'b10, 16'hAB00, 32'h8040_0000, 16'd1, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
